// File: rtl/wb_stat_port.sv
// rtl/wb_stat_port.sv - Wishbone status-code port with FIFO and per-code hold timer for mprj_io[31:16].
// Codes written to DATA queue up and are shown on the pads one at a time, each for at least HOLD cycles.
module wb_stat_port #(
  parameter int          DEPTH      = 4,
  parameter logic [15:0] HOLD_RST   = 16'd16,
  parameter logic [15:0] RESET_CODE = 16'h0000
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [15:0] stat_out,
  output logic [15:0] stat_oeb
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] FULL_LVL = 5'(DEPTH);

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_HOLD = 2'd2;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic [15:0]   timer_q, timer_d;
  logic [15:0]   hold_q, hold_d;
  logic [15:0]   stat_q, stat_d;
  logic [15:0]   oeb_q, oeb_d;
  logic          oe_en_q, oe_en_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [1:0]  reg_sel;
  logic        req, stall, sample, wr, push, pop, flush, busy;
  logic [15:0] hold_load;
  logic        unused_bits;

  assign unused_bits = ^{wbs_sel_i, wbs_dat_i[31:16], wbs_adr_i[1:0]};

  // A full FIFO stalls only DATA writes; the free slot from a same-edge pop is used next edge.
  always_comb begin
    reg_sel   = wbs_adr_i[3:2];
    req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
    stall     = req & wbs_we_i & (reg_sel == REG_DATA) & (level_q == FULL_LVL);
    sample    = req & ~stall;
    wr        = sample & wbs_we_i;
    push      = wr & (reg_sel == REG_DATA);
    flush     = wr & (reg_sel == REG_CTRL) & wbs_dat_i[1];
    pop       = (timer_q == 16'd0) & (level_q != 5'd0);
    busy      = (timer_q != 16'd0) | (level_q != 5'd0);
    hold_load = (hold_q == 16'd0) ? 16'd0 : (hold_q - 16'd1);
  end

  always_comb begin
    ack_d   = sample;
    rdata_d = rdata_q;
    if (sample) begin
      rdata_d = 32'h0;
      if (!wbs_we_i) begin
        case (reg_sel)
          REG_DATA: rdata_d = {16'h0, stat_q};
          REG_CTRL: rdata_d = {24'h0, level_q, busy, 1'b0, oe_en_q};
          REG_HOLD: rdata_d = {16'h0, hold_q};
          default:  rdata_d = 32'h0;
        endcase
      end
    end
  end

  always_comb begin
    hold_d  = hold_q;
    oe_en_d = oe_en_q;
    oeb_d   = oeb_q;
    if (wr && reg_sel == REG_HOLD) begin
      hold_d = wbs_dat_i[15:0];
    end
    if (wr && reg_sel == REG_CTRL) begin
      oe_en_d = wbs_dat_i[0];
      oeb_d   = wbs_dat_i[0] ? 16'h0000 : 16'hFFFF;
    end
  end

  // Flush discards everything queued, including a push at the same edge, but leaves the pads alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    timer_d  = timer_q;
    stat_d   = stat_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = 5'd0;
      timer_d  = 16'd0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        stat_d   = mem_q[rd_ptr_q];
        timer_d  = hold_load;
      end else if (timer_q != 16'd0) begin
        timer_d = timer_q - 16'd1;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + 5'd1;
        2'b01:   level_d = level_q - 5'd1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= 5'd0;
      timer_q  <= 16'd0;
      hold_q   <= HOLD_RST;
      stat_q   <= RESET_CODE;
      oeb_q    <= 16'hFFFF;
      oe_en_q  <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      if (push && !flush) begin
        mem_q[wr_ptr_q] <= wbs_dat_i[15:0];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      timer_q  <= timer_d;
      hold_q   <= hold_d;
      stat_q   <= stat_d;
      oeb_q    <= oeb_d;
      oe_en_q  <= oe_en_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdata_q;
  assign stat_out  = stat_q;
  assign stat_oeb  = oeb_q;

endmodule

// File: tb/tb_wb_stat_port.sv
// tb/tb_wb_stat_port.sv - scoreboard bench for wb_stat_port: read/ack queue and code-order queue checked by a monitor.
module tb_wb_stat_port;

  localparam logic [1:0] R_DATA = 2'd0;
  localparam logic [1:0] R_CTRL = 2'd1;
  localparam logic [1:0] R_HOLD = 2'd2;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  adr = 4'h0;
  logic [31:0] dat_i = 32'h0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] dat_o;
  logic        ack;
  logic [15:0] stat_out, stat_oeb;

  always #5 mclk = ~mclk;

  wb_stat_port #(.DEPTH(4), .HOLD_RST(16'd16), .RESET_CODE(16'h0000)) dut (
    .mclk(mclk), .reset_n(reset_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_adr_i(adr),
    .wbs_dat_i(dat_i), .wbs_sel_i(sel), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .stat_out(stat_out), .stat_oeb(stat_oeb)
  );

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       name;
  } rd_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc_cnt = 0;
  rd_t         rd_q[$];
  rd_t         mon_r;
  logic [15:0] exp_code[$];
  int          chg_cyc[$];
  logic [15:0] chg_val[$];
  logic [15:0] prev_out = 16'h0000;
  logic [15:0] hold_m = 16'd16;

  always @(posedge mclk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack retires the oldest issued access; every change on stat_out retires the oldest code.
  always @(negedge mclk) begin
    if (!reset_n) begin
      prev_out = 16'h0000;
    end else begin
      if (ack) begin
        if (rd_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          mon_r = rd_q.pop_front();
          if (mon_r.chk) check(mon_r.name, dat_o, mon_r.exp);
        end
      end
      if (stat_out !== prev_out) begin
        if (exp_code.size() == 0) check("unexpected_code", {16'h0, stat_out}, {16'h0, prev_out});
        else check("code_order", {16'h0, stat_out}, {16'h0, exp_code.pop_front()});
        chg_cyc.push_back(cyc_cnt);
        chg_val.push_back(stat_out);
        prev_out = stat_out;
      end
    end
  end

  task automatic wb(input logic we_v, input logic [1:0] r, input logic [31:0] d,
                    input bit chk, input logic [31:0] e, input string nm, output int samp);
    int n;
    rd_q.push_back('{chk, e, nm});
    cyc = 1'b1; stb = 1'b1; we = we_v; adr = {r, 2'b00}; dat_i = d; sel = 4'hF;
    n = 0;
    do begin
      @(posedge mclk); #1; n++;
    end while (!ack && n < 600);
    samp = cyc_cnt;
    if (!ack) begin
      check("ack_timeout", 32'd0, 32'd1);
      void'(rd_q.pop_back());
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    int s;
    if (r == R_HOLD) hold_m = d[15:0];
    wb(1'b1, r, d, 1'b0, 32'h0, "wr", s);
  endtask

  task automatic rd(input logic [1:0] r, input logic [31:0] e, input string nm);
    int s;
    wb(1'b0, r, 32'h0, 1'b1, e, nm, s);
  endtask

  task automatic wr_data(input logic [15:0] c, output int s);
    exp_code.push_back(c);
    wb(1'b1, R_DATA, {16'h0, c}, 1'b0, 32'h0, "wd", s);
  endtask

  task automatic clear_chg();
    chg_cyc.delete();
    chg_val.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, s1, n, hold_r;
    int ss[6];
    logic [15:0] code, last;

    // Reset values
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    check("rst_stat_out", {16'h0, stat_out}, 32'h0000);
    check("rst_stat_oeb", {16'h0, stat_oeb}, 32'hFFFF);
    check("rst_ack", {31'h0, ack}, 32'h0);
    reset_n = 1'b1;
    @(posedge mclk); #1;
    rd(R_HOLD, 32'h10, "rst_hold");
    rd(R_CTRL, 32'h00, "rst_ctrl");

    // Two-code sequence
    wr(R_HOLD, 32'd4);
    wr(R_CTRL, 32'd1);
    clear_chg();
    wr_data(16'hAB60, s0);
    wr_data(16'hAB61, s1);
    repeat (12) @(posedge mclk);
    #1;
    check("oeb_enabled", {16'h0, stat_oeb}, 32'h0000);
    check("two_count", 32'(chg_val.size()), 32'd2);
    check("ab60_latency", 32'(chg_cyc[0] - s0), 32'd1);
    check("ab60_duration", 32'(chg_cyc[1] - chg_cyc[0]), 32'd4);
    rd(R_DATA, 32'h0000AB61, "data_readback");

    // Full stall with a long hold
    wr(R_HOLD, 32'd100);
    clear_chg();
    for (int i = 0; i < 6; i++) wr_data(16'hD001 + 16'(i), ss[i]);
    check("no_stall_first5", 32'(ss[4] - ss[0]), 32'd8);
    check("stall_release", 32'(ss[5] - chg_cyc[0]), 32'd101);
    n = 0;
    while (chg_val.size() < 6 && n < 800) begin
      @(posedge mclk); n++;
    end
    #1;
    check("stall_count", 32'(chg_val.size()), 32'd6);
    check("stall_interval", 32'(chg_cyc[1] - chg_cyc[0]), 32'd100);
    repeat (110) @(posedge mclk);
    #1;

    // Flush with three queued entries
    clear_chg();
    wr_data(16'hC001, s0);
    wr_data(16'hC002, s1);
    wr_data(16'hC003, s1);
    wr_data(16'hC004, s1);
    exp_code.delete();
    wr(R_CTRL, 32'h3);
    rd(R_CTRL, 32'h01, "flush_ctrl");
    repeat (150) @(posedge mclk);
    #1;
    check("flush_count", 32'(chg_val.size()), 32'd1);
    check("flush_kept", {16'h0, chg_val[0]}, 32'hC001);
    rd(R_DATA, 32'h0000C001, "flush_data");

    // HOLD = 0 gives a one-cycle display while codes are queued
    wr(R_HOLD, 32'd50);
    clear_chg();
    wr_data(16'h3333, s0);
    wr(R_HOLD, 32'd0);
    wr_data(16'h1111, s1);
    wr_data(16'h2222, s1);
    repeat (70) @(posedge mclk);
    #1;
    check("h0_count", 32'(chg_val.size()), 32'd3);
    check("h0_first_interval", 32'(chg_cyc[1] - chg_cyc[0]), 32'd50);
    check("h0_one_cycle", 32'(chg_cyc[2] - chg_cyc[1]), 32'd1);
    rd(R_HOLD, 32'h0, "h0_hold");

    // Randomized codes, gaps and hold value
    hold_r = $urandom_range(1, 6);
    wr(R_HOLD, 32'(hold_r));
    clear_chg();
    last = 16'h2222;
    for (int i = 0; i < 20; i++) begin
      do code = 16'($urandom); while (code == last);
      last = code;
      wr_data(code, s0);
      repeat ($urandom_range(0, 8)) @(posedge mclk);
      #1;
      if ($urandom_range(0, 3) == 0) rd(R_HOLD, {16'h0, hold_m}, "rand_hold_rd");
    end
    n = 0;
    while (exp_code.size() != 0 && n < 500) begin
      @(posedge mclk); n++;
    end
    #1;
    check("rand_drained", 32'(exp_code.size()), 32'd0);
    check("rand_count", 32'(chg_val.size()), 32'd20);
    for (int i = 1; i < chg_cyc.size(); i++)
      check("rand_hold_min", {31'h0, (chg_cyc[i] - chg_cyc[i-1]) >= hold_r}, 32'd1);
    repeat (hold_r + 5) @(posedge mclk);
    #1;

    // Asynchronous reset during the ack cycle of a DATA write
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'h0; dat_i = 32'h5A5A;
    n = 0;
    do begin
      @(posedge mclk); #1; n++;
    end while (!ack && n < 50);
    check("rst_seen_ack", {31'h0, ack}, 32'd1);
    reset_n = 1'b0;
    exp_code.delete();
    #1;
    check("rst_ack_drop", {31'h0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    reset_n = 1'b1;
    hold_m = 16'd16;
    check("rst2_stat_out", {16'h0, stat_out}, 32'h0000);
    check("rst2_stat_oeb", {16'h0, stat_oeb}, 32'hFFFF);
    @(posedge mclk); #1;
    rd(R_CTRL, 32'h00, "rst2_ctrl");
    rd(R_HOLD, {16'h0, hold_m}, "rst2_hold");
    repeat (4) @(posedge mclk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
